// File: rtl/clken_pkg.sv
// Shared types and helpers for the clock-enable generator.
package clken_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHalt = 2'd1,
    StStep = 2'd2
  } state_e;

  localparam logic [1:0] DivSel0 = 2'd0;
  localparam logic [1:0] DivSel1 = 2'd1;
  localparam logic [1:0] DivSel2 = 2'd2;
  localparam logic [1:0] DivSel3 = 2'd3;

  // Bits needed to hold 0..modulus-1; never less than one.
  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/clken_div.sv
// Modulo-N counter: counts 0..last_i and strobes wrap_o on the terminal count.
module clken_div #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] last_i,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == last_i);
  assign cnt_d  = wrap_o ? '0 : cnt_q + Width'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clken_gen.sv
// CPU clock enable with selectable rate and run/halt/step control, plus a free-running blink
// enable. Define CLKEN_BLINK_PHASE_EN to add the 50%-duty blink_phase_o output.
module clken_gen
  import clken_pkg::*;
#(
  parameter int unsigned DIV0      = 25,
  parameter int unsigned DIV1      = 12,
  parameter int unsigned DIV2      = 5,
  parameter int unsigned DIV3      = 25000000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk25_i,
  input  logic       rst_ni,
  input  logic [1:0] div_sel_i,
  input  logic       halt_i,
  input  logic       step_req_i,
`ifdef CLKEN_BLINK_PHASE_EN
  output logic       blink_phase_o,
`endif
  output logic       cpu_clken_o,
  output logic       blink_clken_o,
  output logic       halted_o,
  output logic       step_ack_o
);

  localparam int unsigned PreW = cnt_width(max4(DIV0, DIV1, DIV2, DIV3));
  localparam int unsigned BlkW = cnt_width(BLINK_DIV);

  localparam logic [PreW-1:0] Last0   = PreW'(DIV0 - 1);
  localparam logic [PreW-1:0] Last1   = PreW'(DIV1 - 1);
  localparam logic [PreW-1:0] Last2   = PreW'(DIV2 - 1);
  localparam logic [PreW-1:0] Last3   = PreW'(DIV3 - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_DIV - 1);

  state_e          state_q, state_d;
  logic [PreW-1:0] act_last_q, act_last_d, sel_last;
  logic            tick, blink_wrap, step_edge, emit, step_done;
  logic            step_req_q, cpu_clken_q, blink_q, halted_q, step_pend_q, step_ack_q;

  always_comb begin
    sel_last = Last0;
    unique case (div_sel_i)
      DivSel0: sel_last = Last0;
      DivSel1: sel_last = Last1;
      DivSel2: sel_last = Last2;
      DivSel3: sel_last = Last3;
    endcase
  end

  // Rate changes only at the wrap, so every period is a whole old or a whole new one.
  assign act_last_d = tick ? sel_last : act_last_q;
  assign step_edge  = step_req_i & ~step_req_q;

  clken_div #(.Width(PreW)) u_pre (
    .clk_i  (clk25_i),
    .rst_ni (rst_ni),
    .last_i (act_last_q),
    .wrap_o (tick)
  );

  clken_div #(.Width(BlkW)) u_blink (
    .clk_i  (clk25_i),
    .rst_ni (rst_ni),
    .last_i (BlkLast),
    .wrap_o (blink_wrap)
  );

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    step_done = 1'b0;
    unique case (state_q)
      StRun: begin
        if (tick) begin
          if (halt_i) state_d = StHalt;
          else        emit    = 1'b1;
        end
      end
      StHalt: begin
        // A step request only counts while halt is still held.
        if (tick && !halt_i) begin
          state_d = StRun;
          emit    = 1'b1;
        end else if (step_edge && halt_i) begin
          state_d = StStep;
        end
      end
      StStep: begin
        if (tick) begin
          state_d   = StHalt;
          emit      = 1'b1;
          step_done = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk25_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      act_last_q  <= Last0;
      step_req_q  <= 1'b0;
      cpu_clken_q <= 1'b0;
      blink_q     <= 1'b0;
      halted_q    <= 1'b0;
      step_pend_q <= 1'b0;
      step_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_last_q  <= act_last_d;
      step_req_q  <= step_req_i;
      cpu_clken_q <= emit;
      blink_q     <= blink_wrap;
      halted_q    <= (state_d != StRun);
      step_pend_q <= step_done;
      step_ack_q  <= step_pend_q;
    end
  end

`ifdef CLKEN_BLINK_PHASE_EN
  logic phase_q;

  always_ff @(posedge clk25_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
    end else if (blink_wrap) begin
      phase_q <= ~phase_q;
    end
  end

  assign blink_phase_o = phase_q;
`endif

  assign cpu_clken_o   = cpu_clken_q;
  assign blink_clken_o = blink_q;
  assign halted_o      = halted_q;
  assign step_ack_o    = step_ack_q;

endmodule

// File: tb/tb_clken_gen.sv
// Scoreboard bench for clken_gen: a tick-schedule reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_clken_gen;

  localparam int unsigned D0 = 4;
  localparam int unsigned D1 = 3;
  localparam int unsigned D2 = 5;
  localparam int unsigned D3 = 6;
  localparam int unsigned BD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] div_sel = 2'd0;
  logic       halt = 1'b0;
  logic       step_req = 1'b0;
  logic       cpu_clken, blink_clken, halted, step_ack;
`ifdef CLKEN_BLINK_PHASE_EN
  logic       blink_phase;
`endif

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  clken_gen #(
    .DIV0      (D0),
    .DIV1      (D1),
    .DIV2      (D2),
    .DIV3      (D3),
    .BLINK_DIV (BD)
  ) dut (
    .clk25_i       (clk),
    .rst_ni        (rst_n),
    .div_sel_i     (div_sel),
    .halt_i        (halt),
    .step_req_i    (step_req),
`ifdef CLKEN_BLINK_PHASE_EN
    .blink_phase_o (blink_phase),
`endif
    .cpu_clken_o   (cpu_clken),
    .blink_clken_o (blink_clken),
    .halted_o      (halted),
    .step_ack_o    (step_ack)
  );

  // {cpu_clken, blink_clken, halted, step_ack, blink_phase}
  typedef logic [4:0] obs_t;
  obs_t exp_q[$];

  function automatic obs_t observed();
    logic ph;
    ph = 1'b0;
`ifdef CLKEN_BLINK_PHASE_EN
    ph = blink_phase;
`endif
    return {cpu_clken, blink_clken, halted, step_ack, ph};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Reference model: absolute tick schedule, mode by name, ack scheduled by cycle index.
  int k, next_tick, ack_at;
  int mode;  // 0 running, 1 halted, 2 one step pending
  bit prev_step, ph_m;
  int divs[4] = '{D0, D1, D2, D3};

  task automatic model_reset();
    k = 0;
    next_tick = D0 - 1;
    ack_at = -1;
    mode = 0;
    prev_step = 0;
    ph_m = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit tick, sedge, emit, blink, ack;
    int nmode;
    tick  = (k == next_tick);
    sedge = step_req && !prev_step;
    prev_step = step_req;
    ack   = (k == ack_at);
    emit  = 0;
    nmode = mode;
    if (tick) next_tick = k + divs[div_sel];
    if (mode == 0 && tick) begin
      if (halt) nmode = 1;
      else emit = 1;
    end else if (mode == 1) begin
      if (tick && !halt) begin
        nmode = 0;
        emit = 1;
      end else if (sedge && halt) begin
        nmode = 2;
      end
    end else if (mode == 2 && tick) begin
      emit = 1;
      nmode = 1;
      ack_at = k + 1;
    end
    mode  = nmode;
    blink = ((k + 1) % BD == 0);
`ifdef CLKEN_BLINK_PHASE_EN
    if (blink) ph_m = !ph_m;
`endif
    exp_q.push_back({emit, blink, (mode != 0), ack, ph_m});
    k++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  int ncyc = 0;
  int last_blink = -1;
  int clken_cnt = 0;
  int ack_cnt = 0;

  task automatic monitor_sample();
    obs_t e;
    ncyc++;
    if (!rst_n) begin
      last_blink = -1;
      check("reset_outputs", observed(), 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", observed(), e);
      if (blink_clken === 1'b1) begin
        if (last_blink >= 0) check("blink_spacing", ncyc - last_blink, BD);
        last_blink = ncyc;
      end
      if (cpu_clken === 1'b1) clken_cnt++;
      if (step_ack === 1'b1) ack_cnt++;
    end
  endtask

  always @(negedge clk) monitor_sample();

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_and_check();
    int j;
    @(negedge clk);
    rst_n = 1'b1;
    for (j = 1; j <= 50; j++) begin
      @(negedge clk);
      if (cpu_clken === 1'b1) break;
    end
    check("first_clken_cycle", j, D0);
    check("halted_after_reset", halted, 0);
  endtask

  initial begin
    int c0, a0, found;
    cycles(3);
    release_and_check();
    cycles(20);

    // Mid-period rate change 0 -> 1.
    cycles(2);
    div_sel = 2'd1;
    cycles(20);
    div_sel = 2'd0;
    cycles(10);

    // Halt, three single steps, resume.
    halt = 1'b1;
    cycles(15);
    check("halted_set", halted, 1);
    c0 = clken_cnt;
    a0 = ack_cnt;
    repeat (3) begin
      step_req = 1'b1;
      cycles(1);
      step_req = 1'b0;
      cycles(14);
    end
    check("step_clken_count", clken_cnt - c0, 3);
    check("step_ack_count", ack_cnt - a0, 3);
    halt = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (cpu_clken === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("resume_clken", found, 1);
    check("resume_halted", halted, 0);

    // Halt release coinciding with a step edge drops the step.
    halt = 1'b1;
    cycles(12);
    a0 = ack_cnt;
    halt = 1'b0;
    step_req = 1'b1;
    cycles(1);
    step_req = 1'b0;
    cycles(12);
    check("conflict_no_ack", ack_cnt - a0, 0);
    check("conflict_running", halted, 0);

    // Random div_sel / halt / step activity.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) div_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      step_req = ($urandom_range(0, 3) == 0);
      cycles(1);
    end
    step_req = 1'b0;
    div_sel = 2'd0;

    // Reset while a step is pending.
    halt = 1'b1;
    cycles(12);
    step_req = 1'b1;
    cycles(1);
    step_req = 1'b0;
    check("pre_reset_halted", halted, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", observed(), 0);
    halt = 1'b0;
    cycles(3);
    release_and_check();
    cycles(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
